// File: rtl/traffic_signal_monitor.sv
// Passive checker for the 4-approach traffic controller lamp outputs.
// Tracks each vehicle head's lamp state and latches the first violation seen.
module traffic_signal_monitor #(
  parameter int MIN_GREEN   = 4,
  parameter int MIN_YELLOW  = 2,
  parameter int MAX_ALL_RED = 16,
  parameter int CW          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s1_g, s2_g, s3_g, s4_g,
  input  logic       s1_y, s2_y, s3_y, s4_y,
  input  logic       s1_r, s2_r, s3_r, s4_r,
  input  logic       P1_g, P2_g, P3_g, P4_g,
  input  logic       P1_r, P2_r, P3_r, P4_r,
  input  logic       fault_clr,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] fault_head,
  output logic       active_valid,
  output logic [1:0] active_head,
  output logic [7:0] phase_count
);

  typedef enum logic [1:0] {ST_RED = 2'd0, ST_GREEN = 2'd1, ST_YELLOW = 2'd2} head_state_t;

  logic [3:0] v_g, v_y, v_r, p_g, p_r;
  assign v_g = {s4_g, s3_g, s2_g, s1_g};
  assign v_y = {s4_y, s3_y, s2_y, s1_y};
  assign v_r = {s4_r, s3_r, s2_r, s1_r};
  assign p_g = {P4_g, P3_g, P2_g, P1_g};
  assign p_r = {P4_r, P3_r, P2_r, P1_r};

  head_state_t   state_q [4];
  head_state_t   state_d [4];
  logic [CW-1:0] dur_q   [4];
  logic [CW-1:0] dur_d   [4];
  logic [CW-1:0] red_cnt_q, red_cnt_d;

  logic [3:0] enc_v, conf_v, seq_v, sy_v, sg_v, ped_v, starve_v;
  logic [3:0] nonred, gy_edge, sel_vec;
  logic [2:0] sel_code;
  logic [1:0] sel_head;
  logic       viol_any, all_red;
  logic       active_valid_d;
  logic [1:0] active_head_d;
  logic [7:0] phase_count_d;

  always_comb begin
    enc_v     = '0;
    seq_v     = '0;
    sy_v      = '0;
    sg_v      = '0;
    ped_v     = '0;
    nonred    = '0;
    gy_edge   = '0;
    for (int n = 0; n < 4; n++) begin
      state_d[n] = state_q[n];
      dur_d[n]   = dur_q[n];
      // A malformed sample leaves the head where it was so it cannot fake a transition.
      if ($onehot({v_g[n], v_y[n], v_r[n]}) && (p_g[n] ^ p_r[n])) begin
        if (v_g[n])      state_d[n] = ST_GREEN;
        else if (v_y[n]) state_d[n] = ST_YELLOW;
        else             state_d[n] = ST_RED;
      end else begin
        enc_v[n] = 1'b1;
      end
      nonred[n]  = (state_d[n] != ST_RED);
      seq_v[n]   = (state_q[n] == ST_GREEN  && state_d[n] == ST_RED)    ||
                   (state_q[n] == ST_YELLOW && state_d[n] == ST_GREEN)  ||
                   (state_q[n] == ST_RED    && state_d[n] == ST_YELLOW);
      gy_edge[n] = (state_q[n] == ST_GREEN && state_d[n] == ST_YELLOW);
      sg_v[n]    = gy_edge[n] && (dur_q[n] < CW'(MIN_GREEN));
      sy_v[n]    = (state_q[n] == ST_YELLOW && state_d[n] == ST_RED) &&
                   (dur_q[n] < CW'(MIN_YELLOW));
      ped_v[n]   = p_g[n] && !v_r[n];
      if (state_d[n] != state_q[n])  dur_d[n] = CW'(1);
      else if (dur_q[n] != '1)       dur_d[n] = dur_q[n] + CW'(1);
    end

    conf_v  = ($countones(nonred) > 1) ? nonred : 4'b0000;
    all_red = (nonred == 4'b0000);
    if (!all_red)               red_cnt_d = '0;
    else if (red_cnt_q != '1)   red_cnt_d = red_cnt_q + CW'(1);
    else                        red_cnt_d = red_cnt_q;
    // Exact-match fires once per run; saturation keeps it from re-firing after wrap.
    starve_v = (all_red && red_cnt_d == CW'(MAX_ALL_RED)) ? 4'b0001 : 4'b0000;

    // Evaluate highest code first so the lowest active code overwrites it.
    sel_code = 3'd0;
    sel_vec  = 4'b0000;
    if (starve_v != 0) begin sel_code = 3'd7; sel_vec = starve_v; end
    if (ped_v    != 0) begin sel_code = 3'd6; sel_vec = ped_v;    end
    if (sg_v     != 0) begin sel_code = 3'd5; sel_vec = sg_v;     end
    if (sy_v     != 0) begin sel_code = 3'd4; sel_vec = sy_v;     end
    if (seq_v    != 0) begin sel_code = 3'd3; sel_vec = seq_v;    end
    if (conf_v   != 0) begin sel_code = 3'd2; sel_vec = conf_v;   end
    if (enc_v    != 0) begin sel_code = 3'd1; sel_vec = enc_v;    end
    viol_any = (sel_code != 3'd0);

    sel_head      = 2'd0;
    active_head_d = 2'd0;
    for (int n = 3; n >= 0; n--) begin
      if (sel_vec[n]) sel_head = 2'(n);
      if (nonred[n])  active_head_d = 2'(n);
    end
    active_valid_d = ($countones(nonred) == 1);
    if (!active_valid_d) active_head_d = 2'd0;
    phase_count_d = phase_count + 8'($countones(gy_edge));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < 4; n++) begin
        state_q[n] <= ST_RED;
        dur_q[n]   <= CW'(1);
      end
      red_cnt_q    <= '0;
      fault        <= 1'b0;
      fault_code   <= 3'd0;
      fault_head   <= 2'd0;
      active_valid <= 1'b0;
      active_head  <= 2'd0;
      phase_count  <= 8'd0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        state_q[n] <= state_d[n];
        dur_q[n]   <= dur_d[n];
      end
      red_cnt_q    <= red_cnt_d;
      active_valid <= active_valid_d;
      active_head  <= active_head_d;
      phase_count  <= phase_count_d;
      // A new violation beats a simultaneous clear; otherwise the record is frozen.
      if (viol_any && (!fault || fault_clr)) begin
        fault      <= 1'b1;
        fault_code <= sel_code;
        fault_head <= sel_head;
      end else if (fault_clr) begin
        fault      <= 1'b0;
        fault_code <= 3'd0;
        fault_head <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_traffic_signal_monitor.sv
// Directed bench for traffic_signal_monitor: legal rotation, starvation, async reset,
// and a table of short runs covering each violation code and the clear rules.
module tb_traffic_signal_monitor;

  localparam int W = 17;
  localparam logic [1:0] R = 2'd0, G = 2'd1, Y = 2'd2, X = 2'd3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] vg, vy, vr, pg, pr;
  logic       fault_clr;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] fault_head;
  logic       active_valid;
  logic [1:0] active_head;
  logic [7:0] phase_count;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  typedef struct packed {
    logic       rst;
    logic       clr;
    logic [7:0] heads;
    logic [3:0] ped;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl [0:22];

  traffic_signal_monitor dut (
    .clk(clk), .reset(reset),
    .s1_g(vg[0]), .s2_g(vg[1]), .s3_g(vg[2]), .s4_g(vg[3]),
    .s1_y(vy[0]), .s2_y(vy[1]), .s3_y(vy[2]), .s4_y(vy[3]),
    .s1_r(vr[0]), .s2_r(vr[1]), .s3_r(vr[2]), .s4_r(vr[3]),
    .P1_g(pg[0]), .P2_g(pg[1]), .P3_g(pg[2]), .P4_g(pg[3]),
    .P1_r(pr[0]), .P2_r(pr[1]), .P3_r(pr[2]), .P4_r(pr[3]),
    .fault_clr(fault_clr),
    .fault(fault), .fault_code(fault_code), .fault_head(fault_head),
    .active_valid(active_valid), .active_head(active_head),
    .phase_count(phase_count)
  );

  // Clock and watchdog
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [W-1:0] ex(logic f, logic [2:0] code, logic [1:0] hd,
                                       logic av, logic [1:0] ah, logic [7:0] pc);
    return {f, code, hd, av, ah, pc};
  endfunction

  function automatic vec_t mk(logic rst, logic clr, logic [7:0] heads, logic [3:0] ped,
                              logic [W-1:0] e);
    vec_t v;
    v.rst = rst; v.clr = clr; v.heads = heads; v.ped = ped; v.exp = e;
    return v;
  endfunction

  // Driver tasks
  task automatic apply(input logic [7:0] heads, input logic [3:0] ped, input logic clr);
    for (int n = 0; n < 4; n++) begin
      case (heads[2*n +: 2])
        G:       begin vg[n] = 1'b1; vy[n] = 1'b0; vr[n] = 1'b0; end
        Y:       begin vg[n] = 1'b0; vy[n] = 1'b1; vr[n] = 1'b0; end
        X:       begin vg[n] = 1'b1; vy[n] = 1'b1; vr[n] = 1'b0; end
        default: begin vg[n] = 1'b0; vy[n] = 1'b0; vr[n] = 1'b1; end
      endcase
    end
    pg = ped;
    pr = ~ped;
    fault_clr = clr;
  endtask

  task automatic check_field(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] e);
    check_field({tag, " fault"},        int'(fault),        int'(e[16]));
    check_field({tag, " fault_code"},   int'(fault_code),   int'(e[15:13]));
    check_field({tag, " fault_head"},   int'(fault_head),   int'(e[12:11]));
    check_field({tag, " active_valid"}, int'(active_valid), int'(e[10]));
    check_field({tag, " active_head"},  int'(active_head),  int'(e[9:8]));
    check_field({tag, " phase_count"},  int'(phase_count),  int'(e[7:0]));
  endtask

  task automatic run_sample(input string tag, input logic [7:0] heads, input logic [3:0] ped,
                            input logic clr, input logic [W-1:0] e);
    @(negedge clk);
    apply(heads, ped, clr);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_all(tag, exp_q.pop_front());
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    apply({R, R, R, R}, 4'b0000, 1'b0);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] heads;
    // Runs: A conflict, B seq + clears, C short yellow, D short green, E ped, F encoding
    tbl[0]  = mk(1, 0, {R, G, R, G}, 4'h0, ex(1, 2, 0, 0, 0, 0));
    tbl[1]  = mk(0, 0, {R, R, R, G}, 4'h0, ex(1, 2, 0, 1, 0, 0));
    tbl[2]  = mk(0, 0, {R, R, R, Y}, 4'h0, ex(1, 2, 0, 1, 0, 1));
    tbl[3]  = mk(1, 0, {R, R, G, R}, 4'h0, ex(0, 0, 0, 1, 1, 0));
    tbl[4]  = mk(0, 0, {R, R, R, R}, 4'h0, ex(1, 3, 1, 0, 0, 0));
    tbl[5]  = mk(0, 1, {R, R, R, R}, 4'h0, ex(0, 0, 0, 0, 0, 0));
    tbl[6]  = mk(0, 0, {R, R, R, G}, 4'h0, ex(0, 0, 0, 1, 0, 0));
    tbl[7]  = mk(0, 0, {R, R, G, G}, 4'h0, ex(1, 2, 0, 0, 0, 0));
    tbl[8]  = mk(0, 1, {R, R, R, Y}, 4'h0, ex(1, 3, 1, 1, 0, 1));
    tbl[9]  = mk(0, 1, {R, R, R, Y}, 4'h0, ex(0, 0, 0, 1, 0, 1));
    tbl[10] = mk(1, 0, {G, R, R, R}, 4'h0, ex(0, 0, 0, 1, 3, 0));
    tbl[11] = mk(0, 0, {G, R, R, R}, 4'h0, ex(0, 0, 0, 1, 3, 0));
    tbl[12] = mk(0, 0, {G, R, R, R}, 4'h0, ex(0, 0, 0, 1, 3, 0));
    tbl[13] = mk(0, 0, {G, R, R, R}, 4'h0, ex(0, 0, 0, 1, 3, 0));
    tbl[14] = mk(0, 0, {Y, R, R, R}, 4'h0, ex(0, 0, 0, 1, 3, 1));
    tbl[15] = mk(0, 0, {R, R, R, R}, 4'h0, ex(1, 4, 3, 0, 0, 1));
    tbl[16] = mk(1, 0, {R, R, R, G}, 4'h0, ex(0, 0, 0, 1, 0, 0));
    tbl[17] = mk(0, 0, {R, R, R, G}, 4'h0, ex(0, 0, 0, 1, 0, 0));
    tbl[18] = mk(0, 0, {R, R, R, G}, 4'h0, ex(0, 0, 0, 1, 0, 0));
    tbl[19] = mk(0, 0, {R, R, R, Y}, 4'h0, ex(1, 5, 0, 1, 0, 1));
    tbl[20] = mk(1, 0, {R, R, G, R}, 4'h2, ex(1, 6, 1, 1, 1, 0));
    tbl[21] = mk(1, 0, {R, X, R, R}, 4'h0, ex(1, 1, 2, 0, 0, 0));
    tbl[22] = mk(0, 0, {R, R, R, R}, 4'h0, ex(1, 1, 2, 0, 0, 0));

    reset = 1'b1;
    apply({R, R, R, R}, 4'b0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", ex(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;

    // Legal rotation: each head G 5, Y 2, handing straight to the next head.
    for (int h = 0; h < 4; h++) begin
      for (int k = 0; k < 7; k++) begin
        heads = {R, R, R, R};
        heads[2*h +: 2] = (k < 5) ? G : Y;
        run_sample($sformatf("rot h%0d k%0d", h, k), heads, 4'h0, 1'b0,
                   ex(0, 0, 0, 1, 2'(h), 8'(h + ((k >= 5) ? 1 : 0))));
      end
    end

    // Starvation: fires on the 16th consecutive all-red sample.
    for (int k = 1; k <= 16; k++) begin
      run_sample($sformatf("starve %0d", k), {R, R, R, R}, 4'h0, 1'b0,
                 (k == 16) ? ex(1, 7, 0, 0, 0, 4) : ex(0, 0, 0, 0, 0, 4));
    end
    run_sample("post starve 1", {R, R, R, G}, 4'h0, 1'b0, ex(1, 7, 0, 1, 0, 4));
    run_sample("post starve 2", {R, R, R, G}, 4'h0, 1'b0, ex(1, 7, 0, 1, 0, 4));

    // Asynchronous reset in the middle of a green, away from any clock edge.
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check_all("async reset", ex(0, 0, 0, 0, 0, 0));
    #1 reset = 1'b0;
    run_sample("green after reset", {R, R, R, G}, 4'h0, 1'b0, ex(0, 0, 0, 1, 0, 0));

    for (int i = 0; i <= 22; i++) begin
      if (tbl[i].rst) do_reset();
      run_sample($sformatf("vec %0d", i), tbl[i].heads, tbl[i].ped, tbl[i].clr, tbl[i].exp);
    end

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
